// File: rtl/ram_1_pkg.sv
// ram_1_pkg: shared constants for the ram_1 storage primitive.
//   ADDR_WIDTH_DEF : default address width (depth = 2^ADDR_WIDTH)
//   DATA_WIDTH_DEF : default word width
//   depth()        : number of words for a given address width
package ram_1_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    // Word count for an address width; every address value is a valid word.
    function automatic int unsigned depth(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

endpackage : ram_1_pkg

// File: rtl/ram_1_if.sv
// ram_1_if: access bus for the single-port RAM.
//   we     : write enable, 1 = store i_data at addr on this edge
//   addr   : word address shared by read and write
//   i_data : write data
//   o_data : registered read data (driven by the RAM)
// Modports: master drives the access, slave is the RAM.
interface ram_1_if
    import ram_1_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] i_data;
    logic [DATA_WIDTH-1:0] o_data;

    modport master (
        output we,
        output addr,
        output i_data,
        input  o_data
    );

    modport slave (
        input  we,
        input  addr,
        input  i_data,
        output o_data
    );

endinterface : ram_1_if

// File: rtl/ram_1.sv
// ram_1: single-port synchronous RAM, flop-based, read-first.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset; clears every word and o_data
//   bus : ram_1_if.slave (we, addr, i_data in; o_data out)
// Read latency is one cycle; a write and a read of the same word on the
// same edge return the word's previous contents.
module ram_1
    import ram_1_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic  clk,
    input  logic  rst,
    ram_1_if.slave bus
);

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DEPTH-1:0]      wr_sel;

    // Per-word write decode: each word either loads i_data or holds.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        assign wr_sel[w] = bus.we && (bus.addr == ADDR_WIDTH'(w));
        assign mem_d[w]  = wr_sel[w] ? bus.i_data : mem_q[w];
    end

    // Read from the pre-write contents, giving read-first ordering.
    assign rdata_d = mem_q[bus.addr];

    // Storage and output register; reset wins over any write that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int unsigned w = 0; w < DEPTH; w++) begin
                mem_q[w] <= mem_d[w];
            end
            rdata_q <= rdata_d;
        end
    end

    assign bus.o_data = rdata_q;

endmodule : ram_1

// File: tb/tb_ram_1.sv
// tb_ram_1: directed self-checking bench for ram_1 with hand-computed
// expected read data.
module tb_ram_1;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    ram_1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Apply current inputs on the next rising edge, then settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bus.we     = we;
        bus.addr   = a;
        bus.i_data = d;
    endtask

    initial begin
        int wrap_addr;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        drive(1'b1, 4'd5, 8'hAA);

        // Reset held two cycles with a write pending: write must be dropped.
        tick();
        check_val("rst_c1", bus.o_data, 8'h00);
        tick();
        check_val("rst_c2", bus.o_data, 8'h00);
        rst = 1'b0;
        drive(1'b0, 4'd5, 8'h00);
        tick();
        check_val("rst_rd5", bus.o_data, 8'h00);

        // Single write then read.
        drive(1'b1, 4'd3, 8'd13);
        tick();
        check_val("wr3_old", bus.o_data, 8'h00);
        drive(1'b0, 4'd3, 8'h00);
        tick();
        check_val("rd3", bus.o_data, 8'd13);

        // Sweep write: read-first shows previous contents of each word.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, AW'(i), DW'(i + 10));
            tick();
            check_val($sformatf("sweep_wr%0d", i), bus.o_data,
                      (i == 3) ? 8'd13 : 8'h00);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, AW'(i), 8'h00);
            tick();
            check_val($sformatf("sweep_rd%0d", i), bus.o_data, DW'(i + 10));
        end

        // Read-during-write on address 7.
        drive(1'b1, 4'd7, 8'h11);
        tick();
        check_val("rdw_pre", bus.o_data, 8'd17);
        drive(1'b1, 4'd7, 8'h22);
        tick();
        check_val("rdw_old", bus.o_data, 8'h11);
        drive(1'b0, 4'd7, 8'h00);
        tick();
        check_val("rdw_new", bus.o_data, 8'h22);

        // Wider parent address 18 truncates to word 2.
        wrap_addr = 18;
        drive(1'b1, AW'(wrap_addr), 8'h5A);
        tick();
        check_val("wrap_old", bus.o_data, 8'd12);
        drive(1'b0, 4'd2, 8'h00);
        tick();
        check_val("wrap_rd2", bus.o_data, 8'h5A);
        drive(1'b0, 4'd3, 8'h00);
        tick();
        check_val("wrap_rd3", bus.o_data, 8'd13);

        // Fill with a distinct pattern, then verify it.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, AW'(i), DW'(i) ^ 8'hC3);
            tick();
        end
        drive(1'b0, 4'd9, 8'h00);
        tick();
        check_val("fill_rd9", bus.o_data, 8'hCA);

        // One-cycle reset pulse mid-operation with a write pending.
        rst = 1'b1;
        drive(1'b1, 4'd9, 8'hFF);
        tick();
        check_val("mid_rst", bus.o_data, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, AW'(i), 8'h00);
            tick();
            check_val($sformatf("clr_rd%0d", i), bus.o_data, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram_1
